// File: rtl/lwe_encrypt_seq.sv
// LWE encryption sequencer.
// Clears the MAC, streams N_ROWS key/b/r reads into it, then captures the
// five accumulator lanes mod 2^DATA_WIDTH (with the message encoding folded
// into the b lane) and holds the ciphertext on a valid/ready port.

// One ciphertext word. Loads the low DATA_WIDTH bits of acc + ofs on cap.
// Adding only the low bits is exact mod 2^DATA_WIDTH.
module lwe_ct_lane #(
  parameter int DATA_WIDTH = 12,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cap,
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [DATA_WIDTH-1:0] ofs,
  output logic [DATA_WIDTH-1:0] ct
);

  // Upper accumulator bits vanish under the mod-q reduction.
  logic acc_hi_unused;
  assign acc_hi_unused = ^acc[ACC_WIDTH-1:DATA_WIDTH];

  // Capture register; held between captures so the output stays stable.
  always_ff @(posedge clk) begin
    if (rst)      ct <= '0;
    else if (cap) ct <= acc[DATA_WIDTH-1:0] + ofs;
  end

endmodule

module lwe_encrypt_seq #(
  parameter int DATA_WIDTH = 12,
  parameter int ACC_WIDTH  = 32,
  parameter int N_ROWS     = 256,
  parameter int ADDR_WIDTH = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  msg_bit,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  input  logic [2:0]            r_data,
  output logic                  mla_clr,
  output logic [2:0]            mla_r,
  input  logic [ACC_WIDTH-1:0]  acc_col1,
  input  logic [ACC_WIDTH-1:0]  acc_col2,
  input  logic [ACC_WIDTH-1:0]  acc_col3,
  input  logic [ACC_WIDTH-1:0]  acc_col4,
  input  logic [ACC_WIDTH-1:0]  acc_sum,
  output logic                  ct_valid,
  input  logic                  ct_ready,
  output logic [DATA_WIDTH-1:0] ct_a1,
  output logic [DATA_WIDTH-1:0] ct_a2,
  output logic [DATA_WIDTH-1:0] ct_a3,
  output logic [DATA_WIDTH-1:0] ct_a4,
  output logic [DATA_WIDTH-1:0] ct_b
);

  localparam int NLANE = 5;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_ROWS - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, CAPTURE, OUT} state_t;

  state_t state;
  logic   msg_lat;
  logic   rd_vld;   // mem_rd_en delayed by the 1-cycle read latency
  logic   cap;

  logic [NLANE-1:0][ACC_WIDTH-1:0]  acc_vec;
  logic [NLANE-1:0][DATA_WIDTH-1:0] ofs_vec;
  logic [NLANE-1:0][DATA_WIDTH-1:0] ct_vec;

  // Control FSM; all control outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      mla_clr   <= 1'b0;
      ct_valid  <= 1'b0;
      msg_lat   <= 1'b0;
      rd_vld    <= 1'b0;
    end else begin
      rd_vld  <= mem_rd_en;
      mla_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            msg_lat <= msg_bit;
            mla_clr <= 1'b1;
            busy    <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          mem_rd_en <= 1'b1;
          mem_addr  <= '0;
          state     <= STREAM;
        end
        STREAM: begin
          if (mem_addr == LAST_ADDR) begin
            mem_rd_en <= 1'b0;
            state     <= DRAIN;
          end else begin
            mem_addr <= mem_addr + 1'b1;
          end
        end
        DRAIN: state <= CAPTURE;
        CAPTURE: begin
          ct_valid <= 1'b1;
          state    <= OUT;
        end
        OUT: begin
          if (ct_ready) begin
            ct_valid <= 1'b0;
            if (start) begin
              // back-to-back: this cycle doubles as the next accept cycle
              msg_lat <= msg_bit;
              mla_clr <= 1'b1;
              state   <= CLEAR;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          busy      <= 1'b0;
          mem_rd_en <= 1'b0;
          ct_valid  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // r only reaches the MAC in the cycle its read returns; otherwise add zero.
  assign mla_r = rd_vld ? r_data : 3'd0;

  assign cap     = (state == CAPTURE);
  assign acc_vec = {acc_sum, acc_col4, acc_col3, acc_col2, acc_col1};

  // Message encoding is q/2 on the b lane only.
  always_comb begin
    ofs_vec = '0;
    ofs_vec[NLANE-1][DATA_WIDTH-1] = msg_lat;
  end

  genvar g;
  generate
    for (g = 0; g < NLANE; g++) begin : g_lane
      lwe_ct_lane #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
        .clk (clk),
        .rst (rst),
        .cap (cap),
        .acc (acc_vec[g]),
        .ofs (ofs_vec[g]),
        .ct  (ct_vec[g])
      );
    end
  endgenerate

  assign ct_a1 = ct_vec[0];
  assign ct_a2 = ct_vec[1];
  assign ct_a3 = ct_vec[2];
  assign ct_a4 = ct_vec[3];
  assign ct_b  = ct_vec[4];

endmodule

// File: tb/tb_lwe_encrypt_seq.sv
// Bench for lwe_encrypt_seq: memory + MAC model around the sequencer,
// table of hand-computed ciphertexts, plus backpressure, back-to-back and
// mid-run reset sequences.
module tb_lwe_encrypt_seq;

  localparam int DW  = 12;
  localparam int AW  = 32;
  localparam int NR  = 4;
  localparam int ADW = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           msg_bit = 1'b0;
  logic           ct_ready = 1'b0;
  logic           busy, mem_rd_en, mla_clr, ct_valid;
  logic [ADW-1:0] mem_addr;
  logic [2:0]     r_data = 3'd0;
  logic [2:0]     mla_r;
  logic [AW-1:0]  acc_col1, acc_col2, acc_col3, acc_col4, acc_sum;
  logic [DW-1:0]  ct_a1, ct_a2, ct_a3, ct_a4, ct_b;

  int checks = 0;
  int errors = 0;

  lwe_encrypt_seq #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .N_ROWS(NR)) dut (
    .clk(clk), .rst(rst), .start(start), .msg_bit(msg_bit), .busy(busy),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .r_data(r_data),
    .mla_clr(mla_clr), .mla_r(mla_r),
    .acc_col1(acc_col1), .acc_col2(acc_col2), .acc_col3(acc_col3),
    .acc_col4(acc_col4), .acc_sum(acc_sum),
    .ct_valid(ct_valid), .ct_ready(ct_ready),
    .ct_a1(ct_a1), .ct_a2(ct_a2), .ct_a3(ct_a3), .ct_a4(ct_a4), .ct_b(ct_b)
  );

  always #5 clk = ~clk;

  // ---- memories (1-cycle latency) and MAC model ----
  logic [DW-1:0]  colm [4][NR];
  logic [DW-1:0]  bm   [NR];
  logic [2:0]     rm   [NR];
  logic [ADW-1:0] rd_addr = '0;
  int             acc [5];

  function automatic int sx3(input logic [2:0] v);
    return v[2] ? int'(v) - 8 : int'(v);
  endfunction

  // r_data is garbage whenever no read was issued the cycle before.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      rd_addr <= mem_addr;
      r_data  <= rm[mem_addr];
    end else begin
      r_data  <= 3'($urandom);
    end
  end

  always @(posedge clk) begin
    if (mla_clr) begin
      for (int i = 0; i < 5; i++) acc[i] <= 0;
    end else begin
      for (int c = 0; c < 4; c++) acc[c] <= acc[c] + int'(colm[c][rd_addr]) * sx3(mla_r);
      acc[4] <= acc[4] + int'(bm[rd_addr]) * sx3(mla_r);
    end
  end

  assign acc_col1 = acc[0];
  assign acc_col2 = acc[1];
  assign acc_col3 = acc[2];
  assign acc_col4 = acc[3];
  assign acc_sum  = acc[4];

  // ---- vector table ----
  typedef struct packed {
    logic [3:0][DW-1:0] c;
    logic [DW-1:0]      b;
    logic [NR-1:0][2:0] r;
    logic               msg;
    logic [3:0][DW-1:0] ea;
    logic [DW-1:0]      eb;
  } vec_t;

  function automatic vec_t mk(int c1, int c2, int c3, int c4, int b,
                              int r0, int r1, int r2, int r3, int msg,
                              int a1, int a2, int a3, int a4, int eb);
    vec_t t;
    t.c[0] = DW'(c1); t.c[1] = DW'(c2); t.c[2] = DW'(c3); t.c[3] = DW'(c4);
    t.b    = DW'(b);
    t.r[0] = 3'(r0);  t.r[1] = 3'(r1);  t.r[2] = 3'(r2);  t.r[3] = 3'(r3);
    t.msg  = (msg != 0);
    t.ea[0] = DW'(a1); t.ea[1] = DW'(a2); t.ea[2] = DW'(a3); t.ea[3] = DW'(a4);
    t.eb   = DW'(eb);
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input vec_t t);
    for (int row = 0; row < NR; row++) begin
      for (int c = 0; c < 4; c++) colm[c][row] = t.c[c];
      bm[row] = t.b;
      rm[row] = t.r[row];
    end
  endtask

  // Entered at a negedge in IDLE; returns at the negedge where ct_valid is
  // seen (or the bound expires). n counts edges from the accepting edge.
  task automatic start_and_wait(input vec_t t, output int n, output int clr_at,
                                output int rd_cnt);
    bit done;
    load(t);
    msg_bit = t.msg;
    start   = 1'b1;
    n = 0; clr_at = -1; rd_cnt = 0; done = 0;
    while (!done) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n == 1) begin
        start   = 1'b0;
        msg_bit = ~t.msg;   // must not affect the latched bit
      end
      if (mla_clr) clr_at = n;
      if (mem_rd_en) rd_cnt++;
      if (ct_valid || n >= 40) done = 1;
    end
  endtask

  task automatic run_one(input vec_t t, input string tag);
    int n, clr_at, rd_cnt;
    start_and_wait(t, n, clr_at, rd_cnt);
    chk({tag, "_latency"}, n, NR + 4);
    chk({tag, "_clr_cycle"}, clr_at, 1);
    chk({tag, "_rd_count"}, rd_cnt, NR);
    chk({tag, "_a1"}, int'(ct_a1), int'(t.ea[0]));
    chk({tag, "_a2"}, int'(ct_a2), int'(t.ea[1]));
    chk({tag, "_a3"}, int'(ct_a3), int'(t.ea[2]));
    chk({tag, "_a4"}, int'(ct_a4), int'(t.ea[3]));
    chk({tag, "_b"},  int'(ct_b),  int'(t.eb));
    ct_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ct_ready = 1'b0;
    chk({tag, "_idle"}, {30'd0, busy, ct_valid}, 0);
  endtask

  vec_t v [6];

  initial begin
    int n, clr_at, rd_cnt, bad, last_a, last_b;
    bit exp_msg, done;

    v[0] = mk(1, 1, 1, 1, 1,        1, 1, 1, 1,     0,  4, 4, 4, 4, 4);
    v[1] = mk(1, 1, 1, 1, 1,        1, 1, 1, 1,     1,  4, 4, 4, 4, 2052);
    v[2] = mk(1, 2, 3, 0, 2047,    -1,-1,-1,-1,     1,  4092, 4088, 4084, 0, 2052);
    v[3] = mk(1000, 4095, 2048, 7, 3000, 3, 3, 3, 3, 1, 3808, 4084, 0, 84, 1184);
    v[4] = mk(5, 1, 0, 100, 1,     -4,-4,-4,-4,     0,  4016, 4080, 0, 2496, 4080);
    v[5] = mk(2047, 1, 4095, 0, 2048, 1, 0,-2, 3,   1,  4094, 2, 4094, 0, 2048);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {28'd0, busy, mem_rd_en, mla_clr, ct_valid}, 0);
    chk("rst_addr_r", {27'd0, mem_addr, mla_r}, 0);
    chk("rst_ct", int'(ct_a1 | ct_a2 | ct_a3 | ct_a4 | ct_b), 0);
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 6; i++) run_one(v[i], $sformatf("v%0d", i));

    // backpressure: hold ciphertext, ignore start pulses
    start_and_wait(v[3], n, clr_at, rd_cnt);
    chk("bp_latency", n, NR + 4);
    last_a = int'(ct_a2);
    last_b = int'(ct_b);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (!ct_valid || mem_rd_en || mla_clr || int'(ct_a2) != last_a || int'(ct_b) != last_b)
        bad++;
      start = k[0];
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    chk("bp_hold", bad, 0);
    chk("bp_b_value", last_b, 1184);
    ct_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ct_ready = 1'b0;
    chk("bp_release", {30'd0, busy, ct_valid}, 0);

    // back-to-back with alternating msg_bit
    load(v[0]);
    exp_msg  = 1'b0;
    msg_bit  = exp_msg;
    start    = 1'b1;
    ct_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0; clr_at = 0; done = 0;
      while (!done) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        if (mla_clr) clr_at++;
        if (ct_valid || n >= 40) done = 1;
      end
      chk($sformatf("b2b%0d_interval", k), n, NR + 4);
      chk($sformatf("b2b%0d_clr_pulses", k), clr_at, 1);
      chk($sformatf("b2b%0d_a1", k), int'(ct_a1), 4);
      chk($sformatf("b2b%0d_b", k), int'(ct_b), exp_msg ? 2052 : 4);
      exp_msg = ~exp_msg;
      msg_bit = exp_msg;
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ct_ready = 1'b0;
    chk("b2b_idle", {30'd0, busy, ct_valid}, 0);

    // reset during the second STREAM cycle
    load(v[2]);
    msg_bit = 1'b1;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("mid_stream_addr", {29'd0, mem_rd_en, mem_addr}, 5);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ctrl", {28'd0, busy, mem_rd_en, mla_clr, ct_valid}, 0);
    chk("mid_rst_addr_r", {27'd0, mem_addr, mla_r}, 0);
    chk("mid_rst_ct", int'(ct_a1 | ct_a2 | ct_a3 | ct_a4 | ct_b), 0);
    rst = 1'b0;
    run_one(v[2], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
